// File: rtl/mem_stage.sv
// MEM stage: byte-lane data memory, load extension and the MEM/WB pipeline register.
// The debug port reads one memory word combinationally and ignores the pipeline stall.
module mem_stage #(
    parameter int NBITS = 32,
    parameter int RBITS = 5,
    parameter int ABITS = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_enable,
    input  logic [NBITS-1:0] MEM_result,
    input  logic [NBITS-1:0] MEM_Rt,
    input  logic [RBITS-1:0] MEM_rd,
    input  logic [1:0]       MEM_storesize,
    input  logic [2:0]       MEM_loadcontrol,
    input  logic             MEM_memtoreg,
    input  logic             MEM_memread,
    input  logic             MEM_regwrite,
    input  logic             MEM_memwrite,
    input  logic [ABITS-1:0] i_dbg_addr,
    output logic [NBITS-1:0] o_dbg_data,
    output logic [NBITS-1:0] WB_readdata,
    output logic [NBITS-1:0] WB_result,
    output logic [RBITS-1:0] WB_rd,
    output logic             WB_memtoreg,
    output logic             WB_regwrite,
    output logic             WB_misalign
);

    localparam int NLANES = NBITS / 8;

    logic [NBITS-1:0] mem [0:(1<<ABITS)-1];

    logic [ABITS-1:0]  word_idx_s;
    logic [1:0]        lane_s;
    logic [NBITS-1:0]  rd_word_s;
    logic [7:0]        byte_s;
    logic [15:0]       half_s;
    logic              st_mis_s;
    logic              ld_mis_s;
    logic              mis_s;
    logic [NLANES-1:0] be_s;
    logic [NBITS-1:0]  wdata_s;
    logic [NBITS-1:0]  ld_data_s;

    logic [NBITS-1:0] readdata_d, readdata_q;
    logic [NBITS-1:0] result_d,   result_q;
    logic [RBITS-1:0] rd_d,       rd_q;
    logic             memtoreg_d, memtoreg_q;
    logic             regwrite_d, regwrite_q;
    logic             misalign_d, misalign_q;

    // Address decode, alignment check and read lane selection
    always_comb begin
        word_idx_s = MEM_result[ABITS+1:2];
        lane_s     = MEM_result[1:0];
        rd_word_s  = mem[word_idx_s];
        byte_s     = rd_word_s[{lane_s, 3'b000} +: 8];
        half_s     = lane_s[1] ? rd_word_s[31:16] : rd_word_s[15:0];

        case (MEM_storesize)
            2'b01:   st_mis_s = lane_s[0];
            2'b11:   st_mis_s = (lane_s != 2'b00);
            default: st_mis_s = 1'b0;
        endcase

        case (MEM_loadcontrol[1:0])
            2'b01:   ld_mis_s = lane_s[0];
            2'b11:   ld_mis_s = (lane_s != 2'b00);
            default: ld_mis_s = 1'b0;
        endcase

        mis_s = (MEM_memread & ld_mis_s) | (MEM_memwrite & st_mis_s);
    end

    // Store byte enables and lane-replicated write data; reset blocks any write
    always_comb begin
        be_s    = {NLANES{1'b0}};
        wdata_s = MEM_Rt;
        if (i_enable && MEM_memwrite && !st_mis_s && !i_rst) begin
            case (MEM_storesize)
                2'b00: begin
                    be_s    = 4'b0001 << lane_s;
                    wdata_s = {NLANES{MEM_Rt[7:0]}};
                end
                2'b01: begin
                    be_s    = lane_s[1] ? 4'b1100 : 4'b0011;
                    wdata_s = {(NLANES/2){MEM_Rt[15:0]}};
                end
                2'b11: begin
                    be_s    = {NLANES{1'b1}};
                    wdata_s = MEM_Rt;
                end
                default: begin
                    be_s    = {NLANES{1'b0}};
                    wdata_s = MEM_Rt;
                end
            endcase
        end else begin
            be_s    = {NLANES{1'b0}};
            wdata_s = MEM_Rt;
        end
    end

    // Data memory write port; contents survive reset
    always_ff @(posedge i_clk) begin
        for (int l = 0; l < NLANES; l++) begin
            if (be_s[l]) begin
                mem[word_idx_s][l*8 +: 8] <= wdata_s[l*8 +: 8];
            end
        end
    end

    // Load extension; read happens before the same-edge store lands
    always_comb begin
        ld_data_s = {NBITS{1'b0}};
        if (MEM_memread && !ld_mis_s) begin
            case (MEM_loadcontrol[1:0])
                2'b00:   ld_data_s = MEM_loadcontrol[2] ? {{(NBITS-8){1'b0}}, byte_s}
                                                        : {{(NBITS-8){byte_s[7]}}, byte_s};
                2'b01:   ld_data_s = MEM_loadcontrol[2] ? {{(NBITS-16){1'b0}}, half_s}
                                                        : {{(NBITS-16){half_s[15]}}, half_s};
                2'b11:   ld_data_s = rd_word_s;
                default: ld_data_s = {NBITS{1'b0}};
            endcase
        end else begin
            ld_data_s = {NBITS{1'b0}};
        end
    end

    // MEM/WB next state: capture on advance, hold on stall
    always_comb begin
        readdata_d = readdata_q;
        result_d   = result_q;
        rd_d       = rd_q;
        memtoreg_d = memtoreg_q;
        regwrite_d = regwrite_q;
        misalign_d = misalign_q;
        if (i_enable) begin
            readdata_d = ld_data_s;
            result_d   = MEM_result;
            rd_d       = MEM_rd;
            memtoreg_d = MEM_memtoreg;
            regwrite_d = MEM_regwrite & ~mis_s;
            misalign_d = mis_s;
        end else begin
            readdata_d = readdata_q;
            result_d   = result_q;
            rd_d       = rd_q;
            memtoreg_d = memtoreg_q;
            regwrite_d = regwrite_q;
            misalign_d = misalign_q;
        end
    end

    // MEM/WB register with asynchronous clear
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            readdata_q <= {NBITS{1'b0}};
            result_q   <= {NBITS{1'b0}};
            rd_q       <= {RBITS{1'b0}};
            memtoreg_q <= 1'b0;
            regwrite_q <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            readdata_q <= readdata_d;
            result_q   <= result_d;
            rd_q       <= rd_d;
            memtoreg_q <= memtoreg_d;
            regwrite_q <= regwrite_d;
            misalign_q <= misalign_d;
        end
    end

    assign WB_readdata = readdata_q;
    assign WB_result   = result_q;
    assign WB_rd       = rd_q;
    assign WB_memtoreg = memtoreg_q;
    assign WB_regwrite = regwrite_q;
    assign WB_misalign = misalign_q;
    assign o_dbg_data  = mem[i_dbg_addr];

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- MEM stage of the 5-stage pipeline, directly downstream of the EX/MEM register.
- Holds the data memory and performs byte, halfword and word stores using byte-lane enables.
- Sign-/zero-extends load data.
- Includes the MEM/WB pipeline register, so everything the WB stage uses leaves this block registered.
- Provides a combinational word read port for the debug unit.

Parameters:
NBITS  32  datapath width
RBITS  5   register-index width
ABITS  8   data-memory word-address width (2^ABITS words of NBITS bits)

Ports:
i_clk            in   1       clock, rising edge
i_rst            in   1       asynchronous active-high reset
i_enable         in   1       pipeline advance; 0 = stall (debug step mode)
MEM_result       in   NBITS   ALU result; byte address for loads/stores
MEM_Rt           in   NBITS   store data
MEM_rd           in   RBITS   destination register
MEM_storesize    in   2       00 byte, 01 half, 11 word, 10 reserved
MEM_loadcontrol  in   3       [1:0] size (as storesize); [2] 1 = unsigned
MEM_memtoreg     in   1       WB selects memory data
MEM_memread      in   1       load
MEM_regwrite     in   1       register write in WB
MEM_memwrite     in   1       store
i_dbg_addr       in   ABITS   debug word address
o_dbg_data       out  NBITS   debug word, combinational
WB_readdata      out  NBITS   extended load data
WB_result        out  NBITS   forwarded ALU result
WB_rd            out  RBITS   destination register
WB_memtoreg      out  1       registered MEM_memtoreg
WB_regwrite      out  1       registered MEM_regwrite
WB_misalign      out  1       misaligned access flag

Behaviour:
- Reset (asynchronous, on i_rst high): all WB_* outputs go to 0 immediately and are held while i_rst is 1. Memory contents are not cleared. A store in progress is aborted: no write on any edge while i_rst is 1.
- Addressing:
  - Word index = MEM_result[ABITS+1:2].
  - Byte lane = MEM_result[1:0], little-endian (lane 0 = bits 7:0).
  - Upper address bits are ignored, so addresses wrap modulo 2^(ABITS+2).
- Alignment: a half access is misaligned when addr[0]=1. A word access is misaligned when addr[1:0]≠0. Byte accesses are never misaligned.
- Store, performed on the rising edge when i_enable=1, MEM_memwrite=1 and the access is aligned:
  - byte: lane addr[1:0] ← Rt[7:0]
  - half: lanes addr[1]*2 and addr[1]*2+1 ← Rt[15:0]
  - word: all lanes ← Rt
  - Other lanes are unchanged.
  - storesize 10: no write.
  - Misaligned store: no write.
- Load: combinational read of the addressed word, lane select, then extension; the result is registered into WB_readdata.
  - byte: lane selected, then sign-extended (bit2=0) or zero-extended (bit2=1).
  - half: selected by addr[1], then extended the same way.
  - word: no extension.
  - A misaligned load or size 10 gives WB_readdata = 0.
  - When MEM_memread=0, WB_readdata = 0.
- memread and memwrite both 1: the store executes, and WB_readdata carries the pre-store content (read before write).
- MEM/WB register:
  - On the edge with i_enable=1, WB_result, WB_rd, WB_memtoreg and WB_regwrite capture their MEM_* inputs.
  - WB_misalign ← (memread|memwrite) & misaligned.
  - A misaligned access also forces WB_regwrite=0.
- Latency: 1 cycle from MEM inputs to WB outputs. A store is visible to a load on the following cycle.
- Stall (i_enable=0): WB_* outputs hold their values, and no memory write occurs.
- Debug port: o_dbg_data = mem[i_dbg_addr], combinational. It reflects a write on the cycle after the write edge. It is independent of i_enable.

Test Plan:
- Reset mid-operation: assert i_rst asynchronously between clock edges while WB_result=0x1234 → all WB_* read 0 before the next edge. A pending sw to 0x10 does not reach memory: dbg word 4 keeps its old value.
- Word and byte stores: sw 0xDEADBEEF at 0x10, then sb 0x55 at 0x12 → dbg word 4 = 0xDE55BEEF. Then lb at 0x13 → WB_readdata=0xFFFFFFDE. Then lbu at 0x13 → 0x000000DE.
- Halfword: sh 0x8001 at 0x22, then lh at 0x22 → 0xFFFF8001; lhu at 0x22 → 0x00008001; lh at 0x20 → lower half zero-extended or sign-extended per bit2.
- Misalignment: sw at 0x11, lw at 0x12, sh at 0x13 → no memory change. Each gives WB_misalign=1 and WB_regwrite=0 in the next cycle. A byte access at 0x13 gives WB_misalign=0.
- Stall: with i_enable=0 for 3 cycles while MEM_memwrite=1 → memory unchanged and WB_* frozen. When i_enable returns to 1, the store is performed and WB updates in 1 cycle.
- Simultaneous load and store to 0x30 (old 0x1, Rt=0x2) → WB_readdata=0x1 and dbg word 12 = 0x2. Address wrap: sw at 0x400 (ABITS=8) writes word 0.
